// File: rtl/btn_debounce_pkg.sv
// Board-level timing constants and helpers shared by the push-button conditioning stage.
package btn_debounce_pkg;

  localparam int unsigned CLK_HZ                  = 27_000_000;
  localparam int unsigned DEBOUNCE_MS             = 10;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Stability counter width; never below one bit so tiny debounce settings still elaborate.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and
// one-cycle press/release strobes. Input is already polarity-normalised (1 = pressed).
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed_in,
  output logic level_out,
  output logic press_out,
  output logic release_out
);

  localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    sync1_d   = pressed_in;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Conditions NUM_BTN raw, bouncing button pins into clean synchronous levels and
// press/release strobes; polarity is normalised here so channels always see 1 = pressed.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  logic [NUM_BTN-1:0] pressed_raw;

  assign pressed_raw = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .pressed_in (pressed_raw[g]),
      .level_out  (btn_level[g]),
      .press_out  (btn_press[g]),
      .release_out(btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed vector table, hand-written corner
// sequences and randomized pins, all compared against a window-based reference model.
module tb_btn_debounce;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // Reference model: history of what each edge saw, and the model's outputs.
  logic [NB-1:0] raw_h [HMAX];
  bit            rst_h [HMAX];
  int            t = 0;
  logic [NB-1:0] m_level, m_press, m_release;

  // Pressed value the stability logic sees at edge j: the pin sampled two edges
  // earlier, or released if a reset edge sits inside that two-edge pipeline.
  function automatic logic delayedSample(input int j, input int b);
    if (j < 2) return 1'b0;
    if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
    return raw_h[j-2][b];
  endfunction

  function automatic void modelEdge();
    logic [NB-1:0] nl, np, nr;
    bit acc;
    nl = m_level; np = '0; nr = '0;
    if (rst_h[t]) begin
      nl = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        acc = (t >= DC - 1);
        for (int j = t - DC + 1; j <= t; j++) begin
          if (j < 0 || rst_h[j] || delayedSample(j, b) == m_level[b]) acc = 0;
        end
        if (acc) begin
          nl[b] = ~m_level[b];
          np[b] = nl[b];
          nr[b] = ~nl[b];
        end
      end
    end
    m_level = nl; m_press = np; m_release = nr;
  endfunction

  task automatic applyStimulus(input logic r, input logic [NB-1:0] raw);
    rst     = r;
    btn_raw = raw;
  endtask

  task automatic checkOutput(input string name, input logic [NB-1:0] lvl,
                             input logic [NB-1:0] prs, input logic [NB-1:0] rel);
    n_cmp++;
    if ({btn_level, btn_press, btn_release} !== {lvl, prs, rel}) begin
      n_fail++;
      $display("[TB] FAIL %s edge=%0d: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
               name, t, btn_level, btn_press, btn_release, lvl, prs, rel);
    end
  endtask

  // One clock edge: record what the DUT samples, advance the model, compare.
  task automatic stepEdge(input string name);
    @(posedge clk);
    raw_h[t] = ~btn_raw;
    rst_h[t] = (rst === 1'b1);
    modelEdge();
    #1;
    checkOutput({name, "/model"}, m_level, m_press, m_release);
    if ((btn_press & btn_release) != '0) begin
      n_fail++;
      $display("[TB] FAIL %s strobe_overlap: press=%b release=%b, required disjoint", name, btn_press, btn_release);
    end
    t++;
  endtask

  typedef struct {
    logic          r;
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic r, input logic [NB-1:0] raw, input logic [NB-1:0] lvl,
                                 input logic [NB-1:0] prs, input logic [NB-1:0] rel);
    vec_t v;
    v.r = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [NB-1:0] lv, pr;
    logic [NB-1:0] rr;

    // Reset, idle, clean press of button 0, then clean release.
    for (int i = 0; i < 3; i++) addVec(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) addVec(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) addVec(1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    addVec(1'b0, 2'b10, 2'b01, 2'b01, 2'b00);
    addVec(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    addVec(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) addVec(1'b0, 2'b11, 2'b01, 2'b00, 2'b00);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 2'b01);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);

    applyStimulus(1'b1, 2'b11);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].raw);
      stepEdge("table");
      checkOutput($sformatf("table[%0d]", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel);
    end

    // Bounce burst on button 0 must never be accepted.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, (i < 8) ? {1'b1, 1'(i % 2)} : 2'b11);
      stepEdge("bounce");
      checkOutput("bounce", 2'b00, 2'b00, 2'b00);
    end

    // Reset at edge 4 of a held press discards the pending change.
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(e == 4, 2'b10);
      stepEdge("rst_mid");
      pr = (e == 10) ? 2'b01 : 2'b00;
      lv = (e >= 10) ? 2'b01 : 2'b00;
      checkOutput("rst_mid", lv, pr, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 2'b11);
      stepEdge("rst_mid_release");
    end

    // Both buttons pressed two cycles apart; strobes follow their own inputs.
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0, (e >= 3) ? 2'b00 : 2'b10);
      stepEdge("indep");
      pr = (e == 6) ? 2'b01 : (e == 8) ? 2'b10 : 2'b00;
      lv = {1'(e >= 8), 1'(e >= 6)};
      checkOutput("indep", lv, pr, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 2'b11);
      stepEdge("indep_release");
    end
    checkOutput("indep_idle", 2'b00, 2'b00, 2'b00);

    // Randomized pins with occasional resets, checked only against the model.
    rr = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(5) == 0) rr[b] = ~rr[b];
      applyStimulus($urandom_range(63) == 0, rr);
      stepEdge("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
